// File: rtl/scan_mux.sv
// Registered N:1 channel multiplexer with direct select and time-division auto-scan.
// Output carries a valid strobe, source channel index and a once-per-frame wrap pulse.
module scan_mux #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned DATA_W = 1,
  parameter int unsigned DWELL  = 1,
  localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     mode_i,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic [NUM_CH-1:0]        mask_i,
  input  logic [NUM_CH*DATA_W-1:0] din_i,
  output logic [DATA_W-1:0]        dout_o,
  output logic [SEL_W-1:0]         ch_out_o,
  output logic                     valid_o,
  output logic                     wrap_o
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [DATA_W-1:0] din_arr [NUM_CH];

  logic [DATA_W-1:0] dout_q, dout_d;
  logic [SEL_W-1:0]  ch_out_q, ch_out_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;
  logic [SEL_W-1:0]  ch_ptr_q, ch_ptr_d;
  logic [CNT_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic              mode_q, mode_d;
  logic              slot_end;

  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      din_arr[i] = din_i[i*DATA_W +: DATA_W];
    end
  end

  assign slot_end = (dwell_cnt_q == CNT_W'(DWELL - 1));

  always_comb begin
    dout_d      = dout_q;
    ch_out_d    = ch_out_q;
    valid_d     = 1'b0;
    wrap_d      = 1'b0;
    ch_ptr_d    = ch_ptr_q;
    dwell_cnt_d = dwell_cnt_q;
    mode_d      = mode_i;

    if (!mode_i) begin
      if (en_i) begin
        dout_d   = din_arr[sel_i];
        ch_out_d = sel_i;
        valid_d  = 1'b1;
      end
    end else if (!mode_q) begin
      // Scan entry: restart the sweep at channel 0 whatever en says.
      ch_ptr_d    = '0;
      dwell_cnt_d = '0;
    end else if (en_i) begin
      if (slot_end) begin
        dwell_cnt_d = '0;
        ch_ptr_d    = ch_ptr_q + SEL_W'(1);
        wrap_d      = (ch_ptr_q == SEL_W'(NUM_CH - 1));
        // Masked channels still consume their slot so the frame length stays fixed.
        if (mask_i[ch_ptr_q]) begin
          dout_d   = din_arr[ch_ptr_q];
          ch_out_d = ch_ptr_q;
          valid_d  = 1'b1;
        end
      end else begin
        dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q      <= '0;
      ch_out_q    <= '0;
      valid_q     <= 1'b0;
      wrap_q      <= 1'b0;
      ch_ptr_q    <= '0;
      dwell_cnt_q <= '0;
      mode_q      <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      ch_out_q    <= ch_out_d;
      valid_q     <= valid_d;
      wrap_q      <= wrap_d;
      ch_ptr_q    <= ch_ptr_d;
      dwell_cnt_q <= dwell_cnt_d;
      mode_q      <= mode_d;
    end
  end

  assign dout_o   = dout_q;
  assign ch_out_o = ch_out_q;
  assign valid_o  = valid_q;
  assign wrap_o   = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: a 16x1 direct-mode instance and a 4x8 DWELL=3 scan instance,
// the latter tracked every cycle by a slot-arithmetic reference model.
module tb_scan_mux;

  localparam int NB = 4;
  localparam int DB = 8;
  localparam int WB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        en_a, mode_a;
  logic [3:0]  sel_a;
  logic [15:0] mask_a, din_a;
  logic        dout_a;
  logic [3:0]  ch_a;
  logic        valid_a, wrap_a;

  logic        en_b, mode_b;
  logic [1:0]  sel_b;
  logic [3:0]  mask_b;
  logic [31:0] din_b;
  logic [7:0]  dout_b;
  logic [1:0]  ch_b;
  logic        valid_b, wrap_b;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected outputs, previous mode, enabled cycles into the frame.
  logic [7:0] m_dout;
  logic [1:0] m_ch;
  logic       m_valid, m_wrap, m_mode;
  int         m_k;

  scan_mux #(.NUM_CH(16), .DATA_W(1), .DWELL(1)) u_dut_a (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en_a),
    .mode_i  (mode_a),
    .sel_i   (sel_a),
    .mask_i  (mask_a),
    .din_i   (din_a),
    .dout_o  (dout_a),
    .ch_out_o(ch_a),
    .valid_o (valid_a),
    .wrap_o  (wrap_a)
  );

  scan_mux #(.NUM_CH(NB), .DATA_W(DB), .DWELL(WB)) u_dut_b (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en_b),
    .mode_i  (mode_b),
    .sel_i   (sel_b),
    .mask_i  (mask_b),
    .din_i   (din_b),
    .dout_o  (dout_b),
    .ch_out_o(ch_b),
    .valid_o (valid_b),
    .wrap_o  (wrap_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict instance B outputs after the coming edge from the current inputs.
  task automatic model_eval();
    if (rst) begin
      m_dout = '0; m_ch = '0; m_valid = 1'b0; m_wrap = 1'b0; m_mode = 1'b0; m_k = 0;
    end else begin
      m_valid = 1'b0;
      m_wrap  = 1'b0;
      if (!mode_b) begin
        if (en_b) begin
          m_dout  = din_b[sel_b*DB +: DB];
          m_ch    = sel_b;
          m_valid = 1'b1;
        end
      end else if (!m_mode) begin
        m_k = 0;
      end else if (en_b) begin
        if (m_k % WB == WB - 1) begin
          int c;
          c = (m_k / WB) % NB;
          m_wrap = (c == NB - 1);
          if (mask_b[c]) begin
            m_dout  = din_b[c*DB +: DB];
            m_ch    = 2'(c);
            m_valid = 1'b1;
          end
        end
        m_k = (m_k + 1) % (NB * WB);
      end
      m_mode = mode_b;
    end
  endtask

  task automatic cyc();
    model_eval();
    @(posedge clk);
    #1;
    chk("b_valid", 32'(valid_b), 32'(m_valid));
    chk("b_wrap", 32'(wrap_b), 32'(m_wrap));
    chk("b_ch", 32'(ch_b), 32'(m_ch));
    chk("b_dout", 32'(dout_b), 32'(m_dout));
  endtask

  task automatic wait_out(input logic [1:0] ch);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc();
      if (valid_b && ch_b == ch) found = 1'b1;
    end
    chk("wait_out_timeout", 32'(found), 32'd1);
  endtask

  initial begin
    logic [3:0] sels [7];
    logic       exps [7];
    int nvalid, nwrap;
    sels = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8};
    exps = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    en_a = 1'b0; mode_a = 1'b0; sel_a = '0; mask_a = '1; din_a = 16'hAAAA;
    en_b = 1'b0; mode_b = 1'b0; sel_b = '0; mask_b = 4'hF;
    din_b = {8'h44, 8'h33, 8'h22, 8'h11};
    m_dout = '0; m_ch = '0; m_valid = 1'b0; m_wrap = 1'b0; m_mode = 1'b0; m_k = 0;

    cyc();
    chk("a_rst_dout", 32'(dout_a), 32'd0);
    chk("a_rst_ch", 32'(ch_a), 32'd0);
    chk("a_rst_valid", 32'(valid_a), 32'd0);
    chk("a_rst_wrap", 32'(wrap_a), 32'd0);
    chk("b_rst_dout", 32'(dout_b), 32'd0);

    // Direct sweep on the 16x1 instance.
    rst = 1'b0; en_a = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sel_a = sels[i];
      cyc();
      chk("a_dir_dout", 32'(dout_a), 32'(exps[i]));
      chk("a_dir_ch", 32'(ch_a), 32'(sels[i]));
      chk("a_dir_valid", 32'(valid_a), 32'd1);
      chk("a_dir_wrap", 32'(wrap_a), 32'd0);
    end
    en_a = 1'b0;

    // Scan entry with en low, then a full frame.
    mode_b = 1'b1;
    cyc();
    chk("b_entry_valid", 32'(valid_b), 32'd0);
    en_b = 1'b1;
    cyc(); cyc(); cyc();
    chk("b_scan_ch0_valid", 32'(valid_b), 32'd1);
    chk("b_scan_ch0_ch", 32'(ch_b), 32'd0);
    chk("b_scan_ch0_dout", 32'(dout_b), 32'h11);
    repeat (9) cyc();
    chk("b_scan_ch3_wrap", 32'(wrap_b), 32'd1);
    chk("b_scan_ch3_ch", 32'(ch_b), 32'd3);
    chk("b_scan_ch3_dout", 32'(dout_b), 32'h44);

    // Mask skip over two frames.
    mask_b = 4'b1010;
    nvalid = 0; nwrap = 0;
    for (int i = 0; i < 24; i++) begin
      cyc();
      nvalid += int'(valid_b);
      nwrap  += int'(wrap_b);
    end
    chk("b_mask_nvalid", 32'(nvalid), 32'd4);
    chk("b_mask_nwrap", 32'(nwrap), 32'd2);

    // Enable stall one cycle after the ch0 output.
    mask_b = 4'hF;
    wait_out(2'd0);
    cyc();
    en_b = 1'b0;
    repeat (5) begin
      cyc();
      chk("b_stall_valid", 32'(valid_b), 32'd0);
    end
    en_b = 1'b1;
    cyc();
    chk("b_resume_early", 32'(valid_b), 32'd0);
    cyc();
    chk("b_resume_valid", 32'(valid_b), 32'd1);
    chk("b_resume_ch", 32'(ch_b), 32'd1);
    chk("b_resume_dout", 32'(dout_b), 32'h22);

    // Reset in the middle of the ch2 slot.
    cyc();
    rst = 1'b1;
    cyc();
    chk("b_mrst_dout", 32'(dout_b), 32'd0);
    chk("b_mrst_ch", 32'(ch_b), 32'd0);
    chk("b_mrst_valid", 32'(valid_b), 32'd0);
    chk("b_mrst_wrap", 32'(wrap_b), 32'd0);
    rst = 1'b0;
    cyc();
    cyc(); cyc(); cyc();
    chk("b_mrst_ch0_valid", 32'(valid_b), 32'd1);
    chk("b_mrst_ch0_dout", 32'(dout_b), 32'h11);

    // Scan -> direct -> scan.
    wait_out(2'd1);
    cyc();
    mode_b = 1'b0; sel_b = 2'd1;
    cyc();
    chk("b_sw_dir_valid", 32'(valid_b), 32'd1);
    chk("b_sw_dir_ch", 32'(ch_b), 32'd1);
    chk("b_sw_dir_dout", 32'(dout_b), 32'h22);
    mode_b = 1'b1;
    cyc();
    chk("b_sw_entry_valid", 32'(valid_b), 32'd0);
    cyc(); cyc(); cyc();
    chk("b_sw_ch0_valid", 32'(valid_b), 32'd1);
    chk("b_sw_ch0_ch", 32'(ch_b), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 19) == 0) mode_b = ~mode_b;
      en_b   = ($urandom_range(0, 3) != 0);
      sel_b  = 2'($urandom_range(0, 3));
      mask_b = 4'($urandom);
      din_b  = $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised, registered N-to-1 channel multiplexer for lab datapath/display designs.
- Two modes:
  - Direct: the caller supplies the select, as a classic N:1 mux.
  - Auto-scan: an internal channel pointer sweeps all channels in time-division order, holding each slot for a programmable number of cycles.
- The output is registered and carries a valid strobe, the source channel index and a sweep-wrap flag, so downstream logic can demultiplex the stream.

Parameters:
- NUM_CH, 16, number of input channels; power of 2, >= 2.
- DATA_W, 1, width of each channel in bits; >= 1.
- DWELL, 1, cycles per scan slot; >= 1.
- SEL_W, $clog2(NUM_CH), select/index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  advance/sample enable. When low, counters freeze and valid is 0.
- mode  input  1  0 = direct, 1 = auto-scan.
- sel  input  SEL_W  channel select; used in direct mode only.
- mask  input  NUM_CH  per-channel scan enable; bit i = 1 lets channel i produce output in scan mode.
- din  input  NUM_CH*DATA_W  packed channels; channel i = din[i*DATA_W +: DATA_W].
- dout  output  DATA_W  registered selected data.
- ch_out  output  SEL_W  channel index of dout.
- valid  output  1  one-cycle strobe: dout/ch_out updated this cycle.
- wrap  output  1  one-cycle pulse at the end of the slot for channel NUM_CH-1 (scan mode).

Behaviour:
- Reset (rst=1 at a clock edge, overrides everything):
  - dout=0, ch_out=0, valid=0, wrap=0.
  - Internal ch_ptr=0, dwell_cnt=0, mode_q=0.
  - Mid-operation reset discards the slot in progress.
- mode_q registers mode every non-reset cycle, independent of en.
- Direct mode (mode=0), all updates take effect at the next edge:
  - en=1: dout<=din[sel], ch_out<=sel, valid<=1, wrap<=0. Latency is 1 cycle from sel/din to dout.
  - en=0: valid<=0, wrap<=0; dout and ch_out hold.
  - ch_ptr and dwell_cnt hold in direct mode.
- Scan entry (mode=1 while mode_q=0):
  - ch_ptr<=0, dwell_cnt<=0, valid<=0, wrap<=0, regardless of en.
  - The sweep restarts cleanly at channel 0.
- Scan mode (mode=1, mode_q=1, en=1):
  - If dwell_cnt < DWELL-1: dwell_cnt++, valid<=0, wrap<=0.
  - If dwell_cnt == DWELL-1 (end of slot):
    - dwell_cnt<=0.
    - ch_ptr<=ch_ptr+1, wrapping from NUM_CH-1 to 0 (natural SEL_W overflow).
    - wrap<=1 iff ch_ptr==NUM_CH-1.
    - If mask[ch_ptr]=1: dout<=din[ch_ptr], ch_out<=ch_ptr, valid<=1.
    - Else: valid<=0; dout and ch_out hold. The slot time is still consumed (fixed TDM frame).
  - With DWELL=1 every enabled cycle is an end of slot.
  - The frame period is NUM_CH*DWELL enabled cycles.
- Scan mode, en=0:
  - dwell_cnt and ch_ptr freeze; valid<=0, wrap<=0; dout and ch_out hold.
  - Resuming continues the same slot without restarting it.
- Leaving scan mode (mode 1->0): the direct-mode rules apply immediately. ch_ptr is kept but is reset on the next scan entry.
- mask=all zeros in scan mode: valid is never asserted; wrap still pulses once per frame.
- din is sampled only at the end-of-slot edge; changes to din mid-slot are ignored.
- valid and wrap are never asserted for more than one consecutive cycle when DWELL > 1.

Test Plan:
- Direct sweep:
  - Setup: NUM_CH=16, DATA_W=1, din=16'hAAAA, mode=0, en=1.
  - Stimulus: sel = 0,1,3,4,5,6,8 on successive cycles.
  - Required: one cycle later dout = 0,1,1,0,1,0,0, each with valid=1, ch_out=sel, wrap=0.
- Scan, DWELL=3:
  - Setup: NUM_CH=4, DATA_W=8, din={8'h44,8'h33,8'h22,8'h11}, mask=4'hF. Reset, then mode=1 (entry cycle), then en=1.
  - Required: valid pulses every 3rd cycle with (ch_out,dout) = (0,11),(1,22),(2,33),(3,44),(0,11)...
  - Required: wrap=1 only together with ch_out=3.
- Mask skip:
  - Setup: same as the previous scenario, with mask=4'b1010.
  - Required: valid only for (1,22) and (3,44), spaced 6 cycles apart; dout holds 22 through the channel-2 slot; wrap still pulses every 12 cycles.
- Enable stall:
  - Stimulus: in scan mode with DWELL=3, drop en for 5 cycles one cycle after the ch0 output.
  - Required: no valid during the stall; ch1 output appears 2 enabled cycles after en returns.
- Reset mid-slot:
  - Stimulus: assert rst for 1 cycle during the ch2 slot.
  - Required: the next edge shows dout=0, ch_out=0, valid=0, wrap=0.
  - Required: with mode held at 1, scan entry occurs, then channel 0 is output after 3 enabled cycles.
- Mode switch:
  - Stimulus: scan at ch2 -> mode=0 with sel=1 -> mode=1.
  - Required: the direct cycle outputs channel 1 with 1-cycle latency; re-entry restarts the sweep at ch0.
